// File: rtl/vliw_pkg.sv
// -----------------------------------------------------------------------------
// vliw_pkg
// Shared definitions for the two-slot (ALU + MEM) VLIW pipeline control logic.
//   hazState_e  : sequencing state of the hazard controller (RUN, WAIT)
//   pipeCtrl_t  : one cycle's worth of PC / pipeline-register controls
//   REG_ADDR_W  : register-file address width
//   DATA_W      : datapath width, also used for the performance counters
//   WAIT_CNT_W  : width of the memory wait counter (covers MEM_TIMEOUT <= 255)
//   satInc()    : saturating increment for DATA_W-wide counters
// -----------------------------------------------------------------------------
package vliw_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 32;
    localparam int WAIT_CNT_W = 8;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hazState_e;

    typedef struct packed {
        logic pcWrite;
        logic p1Write;
        logic p2Write;
        logic p3Write;
        logic p4Write;
        logic p1Flush;
        logic p2Bubble;
        logic p4Bubble;
    } pipeCtrl_t;

    // Canned control words: {pc,p1,p2,p3,p4 write, p1Flush, p2Bubble, p4Bubble}
    localparam pipeCtrl_t CTRL_NORMAL   = pipeCtrl_t'(8'b11111_000);
    localparam pipeCtrl_t CTRL_STALL    = pipeCtrl_t'(8'b00111_010);
    localparam pipeCtrl_t CTRL_REDIRECT = pipeCtrl_t'(8'b11111_110);
    localparam pipeCtrl_t CTRL_FREEZE   = pipeCtrl_t'(8'b00000_001);
    localparam pipeCtrl_t CTRL_RESET    = pipeCtrl_t'(8'b00000_111);

    function automatic logic [DATA_W-1:0] satInc(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + DATA_W'(1);
    endfunction

endpackage

// File: rtl/vliw_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// vliw_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   ID status  : id_valid, id_alu_rm/rn, id_mem_rn/rd, id_alu_useRn, id_mem_useRd
//   EX status  : ex_valid, ex_memRead, ex_mem_rd, ex_redirect
//   MEM status : mem_access, dmem_ready
//   Controls   : pc_write, p1..p4_write, p1_flush, p2_bubble, p4_bubble,
//                mem_timeout (sticky abandon flag)
//   Optional   : stall_cnt, flush_cnt, wait_cnt when HAZARD_PERF_CNT_EN is defined
// Modports: master = pipeline side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface vliw_hazard_ctrl_if;
    import vliw_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_alu_rm;
    logic [REG_ADDR_W-1:0] id_alu_rn;
    logic [REG_ADDR_W-1:0] id_mem_rn;
    logic [REG_ADDR_W-1:0] id_mem_rd;
    logic                  id_alu_useRn;
    logic                  id_mem_useRd;
    logic                  ex_valid;
    logic                  ex_memRead;
    logic [REG_ADDR_W-1:0] ex_mem_rd;
    logic                  ex_redirect;
    logic                  mem_access;
    logic                  dmem_ready;

    logic                  pc_write;
    logic                  p1_write;
    logic                  p2_write;
    logic                  p3_write;
    logic                  p4_write;
    logic                  p1_flush;
    logic                  p2_bubble;
    logic                  p4_bubble;
    logic                  mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [DATA_W-1:0]     stall_cnt;
    logic [DATA_W-1:0]     flush_cnt;
    logic [DATA_W-1:0]     wait_cnt;
`endif

    modport master (
        output id_valid, id_alu_rm, id_alu_rn, id_mem_rn, id_mem_rd,
               id_alu_useRn, id_mem_useRd,
               ex_valid, ex_memRead, ex_mem_rd, ex_redirect,
               mem_access, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cnt, flush_cnt, wait_cnt,
`endif
        input  pc_write, p1_write, p2_write, p3_write, p4_write,
               p1_flush, p2_bubble, p4_bubble, mem_timeout
    );

    modport slave (
        input  id_valid, id_alu_rm, id_alu_rn, id_mem_rn, id_mem_rd,
               id_alu_useRn, id_mem_useRd,
               ex_valid, ex_memRead, ex_mem_rd, ex_redirect,
               mem_access, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cnt, flush_cnt, wait_cnt,
`endif
        output pc_write, p1_write, p2_write, p3_write, p4_write,
               p1_flush, p2_bubble, p4_bubble, mem_timeout
    );

endinterface

// File: rtl/vliw_load_use_detect.sv
// -----------------------------------------------------------------------------
// vliw_load_use_detect
// Purely combinational load-use hazard detector. Flags a hazard when the EX
// stage holds a valid load whose destination matches any source register that
// the ID-stage bundle actually reads.
//   exValid, exMemRead, exMemRd              : EX-stage load description
//   idValid, idAluRm, idAluRn, idMemRn,
//   idMemRd, idAluUseRn, idMemUseRd          : ID-stage sources and use qualifiers
//   hazard                                   : one-cycle stall required
// -----------------------------------------------------------------------------
module vliw_load_use_detect
    import vliw_pkg::*;
(
    input  logic                  exValid,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exMemRd,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idAluRm,
    input  logic [REG_ADDR_W-1:0] idAluRn,
    input  logic [REG_ADDR_W-1:0] idMemRn,
    input  logic [REG_ADDR_W-1:0] idMemRd,
    input  logic                  idAluUseRn,
    input  logic                  idMemUseRd,
    output logic                  hazard
);

    logic srcMatch;

    // rm and the MEM base register are always read; rn only when the ALU
    // takes its B operand from the register file, rd only for store data.
    assign srcMatch = (exMemRd == idAluRm)
                    | (exMemRd == idMemRn)
                    | (idAluUseRn & (exMemRd == idAluRn))
                    | (idMemUseRd & (exMemRd == idMemRd));

    assign hazard = exValid & exMemRead & idValid & srcMatch;

endmodule

// File: rtl/vliw_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// vliw_hazard_ctrl
// Pipeline sequencing controller for the two-slot VLIW core. Drives the load
// enables, flush and bubble controls of PC, p1 (IF/ID), p2 (ID/EX), p3 (EX/MEM)
// and p4 (MEM/WB). Priority: memory-wait freeze > EX redirect > load-use stall.
//   clk         : core clock
//   reset       : synchronous, active-low reset
//   hz (slave)  : pipeline status in, pipeline controls out
// Parameter MEM_TIMEOUT (2..255): WAIT cycles after which an access is abandoned.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating stall / flush /
// wait counters on the interface.
// -----------------------------------------------------------------------------
module vliw_hazard_ctrl
    import vliw_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    vliw_hazard_ctrl_if.slave hz
);

    // The WAIT cycle whose ordinal equals MEM_TIMEOUT is the abandon cycle.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    hazState_e             state;
    hazState_e             stateNext;
    logic [WAIT_CNT_W-1:0] waitCnt;
    logic [WAIT_CNT_W-1:0] waitCntNext;
    logic                  timeoutFlag;
    logic                  timeoutFlagNext;
    logic                  loadUse;
    logic                  freeze;
    pipeCtrl_t             ctrl;

    vliw_load_use_detect uLoadUse (
        .exValid    (hz.ex_valid),
        .exMemRead  (hz.ex_memRead),
        .exMemRd    (hz.ex_mem_rd),
        .idValid    (hz.id_valid),
        .idAluRm    (hz.id_alu_rm),
        .idAluRn    (hz.id_alu_rn),
        .idMemRn    (hz.id_mem_rn),
        .idMemRd    (hz.id_mem_rd),
        .idAluUseRn (hz.id_alu_useRn),
        .idMemUseRd (hz.id_mem_useRd),
        .hazard     (loadUse)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            waitCnt     <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            state       <= stateNext;
            waitCnt     <= waitCntNext;
            timeoutFlag <= timeoutFlagNext;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        stateNext       = state;
        waitCntNext     = waitCnt;
        timeoutFlagNext = timeoutFlag;
        freeze          = 1'b0;
        ctrl            = CTRL_NORMAL;

        case (state)
            RUN: begin
                if (hz.mem_access && !hz.dmem_ready) begin
                    stateNext   = WAIT;
                    waitCntNext = '0;
                    freeze      = 1'b1;
                end
            end
            WAIT: begin
                if (hz.dmem_ready) begin
                    // Exit cycle: behaves as a completed access in RUN.
                    stateNext   = RUN;
                    waitCntNext = '0;
                end else if (waitCnt == WAIT_LAST) begin
                    // Abandon: the access is treated as complete so p3 can
                    // advance instead of re-requesting forever.
                    stateNext       = RUN;
                    waitCntNext     = '0;
                    timeoutFlagNext = 1'b1;
                end else begin
                    waitCntNext = waitCnt + WAIT_CNT_W'(1);
                    freeze      = 1'b1;
                end
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase

        if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (hz.ex_redirect) begin
            ctrl = CTRL_REDIRECT;
        end else if (loadUse) begin
            ctrl = CTRL_STALL;
        end

        if (!reset) begin
            ctrl = CTRL_RESET;
        end

        hz.pc_write    = ctrl.pcWrite;
        hz.p1_write    = ctrl.p1Write;
        hz.p2_write    = ctrl.p2Write;
        hz.p3_write    = ctrl.p3Write;
        hz.p4_write    = ctrl.p4Write;
        hz.p1_flush    = ctrl.p1Flush;
        hz.p2_bubble   = ctrl.p2Bubble;
        hz.p4_bubble   = ctrl.p4Bubble;
        // Held low while reset is asserted, not just after the reset edge.
        hz.mem_timeout = timeoutFlag & reset;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [DATA_W-1:0] stallCnt;
    logic [DATA_W-1:0] flushCnt;
    logic [DATA_W-1:0] waitCycCnt;
    logic              stallEvt;
    logic              flushEvt;
    logic              waitEvt;

    // Events mirror the action actually taken, so a redirect that masks a
    // load-use counts only as a flush.
    assign stallEvt = !freeze && !hz.ex_redirect && loadUse;
    assign flushEvt = !freeze && hz.ex_redirect;
    assign waitEvt  = (state == WAIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCnt   <= '0;
            flushCnt   <= '0;
            waitCycCnt <= '0;
        end else begin
            if (stallEvt) stallCnt   <= satInc(stallCnt);
            if (flushEvt) flushCnt   <= satInc(flushCnt);
            if (waitEvt)  waitCycCnt <= satInc(waitCycCnt);
        end
    end

    assign hz.stall_cnt = stallCnt;
    assign hz.flush_cnt = flushCnt;
    assign hz.wait_cnt  = waitCycCnt;
`endif

endmodule

// File: tb/tb_vliw_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vliw_hazard_ctrl
// Scoreboard bench for vliw_hazard_ctrl (MEM_TIMEOUT = 4). Each stimulus cycle
// pushes its hand-computed control vector; a monitor on the falling edge pops
// and compares against the DUT outputs.
// Vector order: {pc,p1,p2,p3,p4 write, p1_flush, p2_bubble, p4_bubble, mem_timeout}
// -----------------------------------------------------------------------------
module tb_vliw_hazard_ctrl;
    import vliw_pkg::*;

    localparam int TIMEOUT = 4;

    localparam logic [8:0] E_RST   = 9'b00000_111_0;
    localparam logic [8:0] E_NORM  = 9'b11111_000_0;
    localparam logic [8:0] E_STALL = 9'b00111_010_0;
    localparam logic [8:0] E_REDIR = 9'b11111_110_0;
    localparam logic [8:0] E_FRZ   = 9'b00000_001_0;
    localparam logic [8:0] E_TO    = 9'b00000_000_1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vliw_hazard_ctrl_if hz();

    vliw_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    logic [8:0] expQ[$];
    string      nameQ[$];
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin : monitor
        logic [8:0] act;
        logic [8:0] want;
        string      nm;
        if (expQ.size() > 0) begin
            want = expQ.pop_front();
            nm   = nameQ.pop_front();
            act  = {hz.pc_write, hz.p1_write, hz.p2_write, hz.p3_write, hz.p4_write,
                    hz.p1_flush, hz.p2_bubble, hz.p4_bubble, hz.mem_timeout};
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL %s: got %b want %b", nm, act, want);
            end
        end
    end

    task automatic clrIn();
        hz.id_valid     = 1'b0;
        hz.id_alu_rm    = '0;
        hz.id_alu_rn    = '0;
        hz.id_mem_rn    = '0;
        hz.id_mem_rd    = '0;
        hz.id_alu_useRn = 1'b0;
        hz.id_mem_useRd = 1'b0;
        hz.ex_valid     = 1'b0;
        hz.ex_memRead   = 1'b0;
        hz.ex_mem_rd    = '0;
        hz.ex_redirect  = 1'b0;
        hz.mem_access   = 1'b0;
        hz.dmem_ready   = 1'b0;
    endtask

    task automatic setLoad(input logic [2:0] rd);
        hz.ex_valid   = 1'b1;
        hz.ex_memRead = 1'b1;
        hz.ex_mem_rd  = rd;
        hz.id_valid   = 1'b1;
    endtask

    task automatic setId(input logic [2:0] rm, input logic [2:0] rn,
                         input logic [2:0] mrn, input logic [2:0] mrd,
                         input logic useRn, input logic useRd);
        hz.id_alu_rm    = rm;
        hz.id_alu_rn    = rn;
        hz.id_mem_rn    = mrn;
        hz.id_mem_rd    = mrd;
        hz.id_alu_useRn = useRn;
        hz.id_mem_useRd = useRd;
    endtask

    // Inputs are already applied; queue the expectation and advance one cycle.
    task automatic cyc(input string nm, input logic [8:0] want);
        expQ.push_back(want);
        nameQ.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clrIn();
        @(posedge clk);
        #1;

        // Reset state
        cyc("rst0", E_RST);
        cyc("rst1", E_RST);
        reset = 1'b1;
        cyc("run_first", E_NORM);

        // Load-use variants, load of r3 in EX
        setLoad(3'd3); setId(3'd3, 3'd1, 3'd4, 3'd5, 1'b1, 1'b1);
        cyc("lu_rm", E_STALL);
        hz.ex_valid = 1'b0; hz.ex_memRead = 1'b0;
        cyc("lu_rm_after", E_NORM);
        setLoad(3'd3); setId(3'd5, 3'd3, 3'd4, 3'd6, 1'b0, 1'b0);
        cyc("rn_unused", E_NORM);
        setId(3'd5, 3'd3, 3'd4, 3'd6, 1'b1, 1'b0);
        cyc("rn_used", E_STALL);
        setId(3'd5, 3'd1, 3'd3, 3'd6, 1'b0, 1'b0);
        cyc("mem_rn", E_STALL);
        setId(3'd5, 3'd1, 3'd4, 3'd3, 1'b0, 1'b0);
        cyc("mem_rd_unused", E_NORM);
        setId(3'd5, 3'd1, 3'd4, 3'd3, 1'b0, 1'b1);
        cyc("mem_rd_used", E_STALL);
        setId(3'd3, 3'd1, 3'd4, 3'd5, 1'b0, 1'b0); hz.id_valid = 1'b0;
        cyc("id_invalid", E_NORM);
        hz.id_valid = 1'b1; hz.ex_memRead = 1'b0;
        cyc("not_load", E_NORM);
        hz.ex_memRead = 1'b1; hz.ex_valid = 1'b0;
        cyc("ex_invalid", E_NORM);

        // Redirect beats load-use, no extra stall
        hz.ex_valid = 1'b1; hz.ex_redirect = 1'b1;
        cyc("redir_lu", E_REDIR);
        clrIn(); hz.ex_redirect = 1'b1;
        cyc("redir", E_REDIR);
        clrIn();
        cyc("idle", E_NORM);

        // dmem_ready low for 3 cycles, exit on the 4th
        hz.mem_access = 1'b1; hz.dmem_ready = 1'b0;
        cyc("wait_enter", E_FRZ);
        cyc("wait1", E_FRZ);
        cyc("wait2", E_FRZ);
        hz.dmem_ready = 1'b1;
        cyc("wait_exit", E_NORM);
        clrIn();
        cyc("after_wait", E_NORM);

        // Redirect held during WAIT, acted on in the exit cycle
        hz.mem_access = 1'b1; hz.ex_redirect = 1'b1;
        cyc("wr_enter", E_FRZ);
        cyc("wr_hold", E_FRZ);
        hz.dmem_ready = 1'b1;
        cyc("wr_exit", E_REDIR);

        // Load-use pending across a 1-cycle WAIT
        clrIn(); hz.mem_access = 1'b1;
        setLoad(3'd2); setId(3'd2, 3'd1, 3'd4, 3'd5, 1'b0, 1'b0);
        cyc("wl_enter", E_FRZ);
        hz.dmem_ready = 1'b1;
        cyc("wl_exit", E_STALL);

        // Single-cycle access in RUN
        clrIn(); hz.mem_access = 1'b1; hz.dmem_ready = 1'b1;
        cyc("single_access", E_NORM);

        // Timeout: ready never arrives, abandoned in the 4th WAIT cycle
        clrIn(); hz.mem_access = 1'b1;
        cyc("to_enter", E_FRZ);
        cyc("to_w1", E_FRZ);
        cyc("to_w2", E_FRZ);
        cyc("to_w3", E_FRZ);
        cyc("to_abandon", E_NORM);
        clrIn();
        cyc("to_flag", E_NORM | E_TO);
        cyc("to_hold", E_NORM | E_TO);
        setLoad(3'd1); setId(3'd1, 3'd2, 3'd4, 3'd5, 1'b0, 1'b0);
        cyc("to_hold_stall", E_STALL | E_TO);

        // Reset mid-WAIT
        clrIn(); hz.mem_access = 1'b1;
        cyc("rw_enter", E_FRZ | E_TO);
        cyc("rw_wait", E_FRZ | E_TO);
        reset = 1'b0;
        cyc("rw_reset0", E_RST);
        cyc("rw_reset1", E_RST);
        reset = 1'b1; clrIn();
        cyc("rw_run", E_NORM);

        // Fresh wait after reset: full residency again before abandon
        hz.mem_access = 1'b1;
        cyc("rw2_enter", E_FRZ);
        cyc("rw2_w1", E_FRZ);
        cyc("rw2_w2", E_FRZ);
        cyc("rw2_w3", E_FRZ);
        cyc("rw2_abandon", E_NORM);
        clrIn();
        cyc("rw2_flag", E_NORM | E_TO);

        // Every queued expectation must have been consumed by the monitor
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vliw_hazard_ctrl.md
# vliw_hazard_ctrl

Pipeline sequencing controller for the two-slot (ALU + MEM) VLIW core. Sits beside the ID stage and drives the write-enables, flush and bubble controls of the PC, IF/ID (p1), ID/EX (p2), EX/MEM (p3) and MEM/WB (p4) pipeline registers. Resolves three events: load-use hazards, EX-stage redirects (taken branch or jump), and multi-cycle data-memory accesses with a bounded wait.

## Interface
- MEM_TIMEOUT, default 16: maximum number of cycles spent in WAIT before an access is abandoned; legal range 2..255.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- id_valid  in  1  p1 holds a real instruction bundle.
- id_alu_rm, id_alu_rn, id_mem_rn, id_mem_rd  in  3 each  ID-stage source register fields.
- id_alu_useRn  in  1  ALU slot reads rn (aluSrcB=0).
- id_mem_useRd  in  1  MEM slot reads rd (store data).
- ex_valid  in  1  p2 holds a real bundle.
- ex_memRead  in  1  EX-stage MEM slot is a load.
- ex_mem_rd  in  3  load destination register.
- ex_redirect  in  1  EX resolved a taken branch or a jump.
- mem_access  in  1  MEM stage (p3) holds a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write, p1_write, p2_write, p3_write, p4_write  out  1 each  register load enables.
- p1_flush  out  1  p1 loads a NOP bundle.
- p2_bubble  out  1  p2 loads zeroed control signals.
- p4_bubble  out  1  p4 loads zeroed control signals.
- mem_timeout  out  1  sticky: an access was abandoned.

## Operation
- States: RUN, WAIT. Reset state RUN; wait counter 0; mem_timeout 0.
- Priority within a cycle: WAIT freeze > redirect > load-use.
- RUN, mem_access & !dmem_ready: go to WAIT. Same cycle: all five write enables 0, p4_bubble 1.
- RUN, mem_access & dmem_ready: single-cycle access, no stall.
- RUN, ex_redirect: pc_write 1 (target), p1_flush 1, p2_bubble 1, all writes 1.
- RUN, load-use: ex_valid & ex_memRead & id_valid & ex_mem_rd equals id_alu_rm, or id_mem_rn, or id_alu_rn when id_alu_useRn, or id_mem_rd when id_mem_useRd. Response: pc_write 0, p1_write 0, p2_write 1, p2_bubble 1, p3/p4 write 1. The stall lasts one cycle, then forwarding resolves the dependency.
- RUN, none of the above: all writes 1, no flush or bubble.
- WAIT: all writes 0 and p4_bubble 1 each cycle. The counter increments each cycle.
  - dmem_ready: return to RUN. That cycle behaves as RUN with mem_access & dmem_ready, including any pending redirect or load-use.
  - Counter reaching MEM_TIMEOUT without ready: set mem_timeout, return to RUN, and treat the access as complete.
- ex_redirect asserted during WAIT stays frozen in p2 and is acted on in the exit cycle.
- Redirect coinciding with a load-use: redirect wins and no extra stall cycle occurs.

## Timing
- All outputs are combinational from the current state and inputs. State, counter and mem_timeout update on the rising clk edge.
- While reset is low: all write enables 0, p1_flush, p2_bubble and p4_bubble all 1, mem_timeout cleared.
- The first cycle after reset release evaluates in RUN.
- Load-use penalty: 1 cycle. Redirect penalty: 2 squashed bundles. Minimum WAIT residency: 1 cycle.
- Reset asserted mid-WAIT: the next cycle is RUN with the counter at 0. The pending access is discarded without setting mem_timeout.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt, flush_cnt and wait_cnt (32 bits each, cleared by reset, saturating at all-ones).
  - stall_cnt increments on each load-use cycle.
  - flush_cnt increments on each redirect cycle.
  - wait_cnt increments on each WAIT cycle.
- Undefined: the counters and ports are absent. Control behaviour is identical.

## Structure
- Shared package vliw_pkg holds:
  - the state enum (RUN, WAIT);
  - REG_ADDR_W = 3;
  - DATA_W = 32.
- One combinational sub-module, vliw_load_use_detect: register comparators plus the use qualifiers, producing a single hazard bit.

## Test plan
- Load r3 in EX, ALU bundle in ID with rm=3 → one cycle with pc_write=0, p1_write=0, p2_bubble=1; normal flow on the following cycle.
- Same, but rn=3 with id_alu_useRn=0 → no stall.
- ex_redirect=1 with load-use also true → p1_flush=1, p2_bubble=1, pc_write=1, no stall cycle.
- mem_access with dmem_ready low for 3 cycles → 3 WAIT cycles, all writes 0, p4_bubble=1; exit on the 4th cycle; mem_timeout stays 0.
- MEM_TIMEOUT=4, dmem_ready never asserted → mem_timeout=1 after 4 WAIT cycles; return to RUN; flag held until reset.
- Reset driven low mid-WAIT → all writes 0 during reset; after release, state RUN and counter 0.
